muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the EX stage of the pipelined MIPS CPU.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit_md_negate.sv | 14 +
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPrep = 2'b01,
    StCalc = 2'b10,
    StFix  = 2'b11
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;

  // Pipeline side: issues ops and moves, observes HI/LO and the stall.
  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit_md_negate.sv
// Conditional two's complement. carry_in is normally 1; for the upper half of a
// double-width negation it is the "lower half was zero" carry.
module md_negate #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  negate,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(DATA_WIDTH-1){1'b0}}, carry_in}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO. busy stalls the pipeline.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  md_state_e             state_q;
  md_op_e                op_q;
  // acc_q: multiply high accumulator / divide remainder.
  // mq_q: dividend-or-multiplier in, quotient-or-product-low out.
  // opnd_q: multiplicand / divisor magnitude.
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] mq_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [CntW-1:0]       count_q;
  logic                  neg_lo_q;
  logic                  neg_hi_q;
  logic                  div_zero_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  is_signed;
  logic                  is_div;
  logic                  a_neg;
  logic                  b_neg;
  logic                  lo_neg_en;
  logic                  hi_neg_en;
  logic                  hi_carry;
  logic [DATA_WIDTH-1:0] hi_neg_in;
  logic [DATA_WIDTH-1:0] lo_neg_out;
  logic [DATA_WIDTH-1:0] hi_neg_out;
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ok;

  // Operand/result sign decode and negator steering (PREP: operands, FIX: results).
  always_comb begin
    is_signed = op_is_signed(op_q);
    is_div    = op_is_div(op_q);
    a_neg     = is_signed & mq_q[DATA_WIDTH-1];
    b_neg     = is_signed & opnd_q[DATA_WIDTH-1];
    if (state_q == StPrep) begin
      lo_neg_en = a_neg;
      hi_neg_en = b_neg;
      hi_neg_in = opnd_q;
      hi_carry  = 1'b1;
    end else begin
      lo_neg_en = neg_lo_q;
      hi_neg_en = neg_hi_q;
      hi_neg_in = acc_q;
      // Product negation spans {hi,lo}: hi only absorbs the +1 when lo is all zero.
      hi_carry  = is_div ? 1'b1 : (mq_q == '0);
    end
  end

  md_negate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_neg_lo (
    .value    (mq_q),
    .negate   (lo_neg_en),
    .carry_in (1'b1),
    .result   (lo_neg_out)
  );

  md_negate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_neg_hi (
    .value    (hi_neg_in),
    .negate   (hi_neg_en),
    .carry_in (hi_carry),
    .result   (hi_neg_out)
  );

  // One shift-add / restoring shift-subtract step.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, mq_q[DATA_WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    // When div_ok the difference is below the divisor, so it fits in DATA_WIDTH bits.
    div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpMult;
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      count_q    <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q    <= md_op_e'(bus.op);
            mq_q    <= bus.a;
            opnd_q  <= bus.b;
            busy_q  <= 1'b1;
            state_q <= StPrep;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        StPrep: begin
          mq_q       <= lo_neg_out;
          opnd_q     <= hi_neg_out;
          acc_q      <= '0;
          count_q    <= '0;
          div_zero_q <= is_div && (opnd_q == '0);
          neg_lo_q   <= a_neg ^ b_neg;
          // Remainder follows the dividend; with a zero divisor this restores hi = a.
          neg_hi_q   <= is_div ? a_neg : (a_neg ^ b_neg);
          state_q    <= StCalc;
        end
        StCalc: begin
          if (is_div) begin
            acc_q <= div_ok ? div_diff : div_shift[DATA_WIDTH-1:0];
            mq_q  <= {mq_q[DATA_WIDTH-2:0], div_ok};
          end else begin
            acc_q <= mul_sum[DATA_WIDTH:1];
            mq_q  <= {mul_sum[0], mq_q[DATA_WIDTH-1:1]};
          end
          count_q <= count_q + CntW'(1);
          if (count_q == CntLast) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= hi_neg_out;
          lo_q    <= div_zero_q ? '1 : lo_neg_out;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: scoreboard of reference results, popped on each done pulse.
module tb_muldiv_unit;

  localparam int unsigned DW  = 32;
  localparam int          Lat = DW + 2;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(DW)) bus ();

  muldiv_unit #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model built on the simulator's own arithmetic.
  function automatic res_t model(input logic [1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    res_t        r;
    int          sa;
    int          sbv;
    longint      sp;
    logic [63:0] p;
    sa  = a;
    sbv = b;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sbv);
        p  = sp;
        r  = {p[63:32], p[31:0]};
      end
      2'b01: begin
        p = {32'h0, a} * {32'h0, b};
        r = {p[63:32], p[31:0]};
      end
      2'b10: begin
        if (b == 0)                                    r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          r.lo = sa / sbv;
          r.hi = sa % sbv;
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
  endtask

  // Drive start for one edge (T0) and record the expected result.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges after T0 until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= Lat + 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    rst = 1'b0;
  endtask

  task automatic test_multu_timing();
    int   lat;
    int   busy_cnt;
    res_t e;
    busy_cnt = 0;
    lat      = -1;
    issue(2'b01, 32'd7, 32'd6);
    if (bus.busy) busy_cnt++;
    for (int k = 1; k <= Lat + 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != Lat) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, Lat); end
    checks++; if (busy_cnt != Lat) begin errors++; $display("FAIL multu_busy_cycles got %0d want %0d", busy_cnt, Lat); end
    e = exp_q.pop_front();
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL multu_hi got %h want %h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL multu_lo got %h want %h", bus.lo, e.lo); end
    checks++; if (bus.lo !== 32'h0000_002A) begin errors++; $display("FAIL multu_lo_const got %h want 0000002a", bus.lo); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_arith();
    logic [1:0]    ops [8] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [DW-1:0] as  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000,
                               32'hFFFF_FF9C, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [DW-1:0] bs  [8] = '{32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF,
                               32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            lat;
    res_t          e;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
        if (i % 4 == 0) b = -b;
      end
      issue(op, a, b);
      wait_done(lat);
      checks++;
      if (lat != Lat) begin
        errors++; $display("FAIL arith%0d_latency got %0d want %0d", i, lat, Lat);
      end
      if (lat >= 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL arith%0d_scoreboard got done want none", i);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.hi !== e.hi) begin
            errors++; $display("FAIL arith%0d_hi op %b a %h b %h got %h want %h", i, op, a, b, bus.hi, e.hi);
          end
          checks++;
          if (bus.lo !== e.lo) begin
            errors++; $display("FAIL arith%0d_lo op %b a %h b %h got %h want %h", i, op, a, b, bus.lo, e.lo);
          end
        end
      end else begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_start_while_busy();
    int   lat;
    int   stray;
    res_t e;
    lat   = -1;
    stray = 0;
    issue(2'b00, 32'hFFFF_FFF0, 32'd3);
    for (int k = 1; k <= Lat + 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) begin
        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      end
      if (k == 10) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != Lat) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", lat, Lat); end
    e = exp_q.pop_front();
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL busy_start_hi got %h want %h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL busy_start_lo got %h want %h", bus.lo, e.lo); end
    for (int k = 0; k < Lat + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL busy_start_ghost got %0d want 0", stray); end
  endtask

  task automatic test_moves();
    logic [DW-1:0] hi_before;
    int            lat;
    res_t          e;
    hi_before = bus.hi;
    issue(2'b01, 32'd2, 32'd3);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin bus.mthi = 1'b1; bus.wdata = 32'hA5A5_A5A5; end
      if (k == 5) bus.mthi = 1'b0;
    end
    checks++; if (bus.hi !== hi_before) begin errors++; $display("FAIL mthi_busy got %h want %h", bus.hi, hi_before); end
    wait_done(lat);
    e = exp_q.pop_front();
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL mthi_busy_result got %h want %h", bus.hi, e.hi); end
    bus.mthi = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1; bus.mthi = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_idle got %h want a5a5a5a5", bus.hi); end
    bus.mtlo = 1'b1; bus.wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1; bus.mtlo = 1'b0;
    checks++; if (bus.lo !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mtlo_idle got %h want 5a5a5a5a", bus.lo); end
    checks++; if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo_keeps_hi got %h want a5a5a5a5", bus.hi); end
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_mtlo_both got %h/%h want 12345678", bus.hi, bus.lo);
    end
    bus.wdata = 32'hDEAD_BEEF;
    issue(2'b11, 32'd100, 32'd7);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h1234_5678) begin
      errors++; $display("FAIL start_beats_move got %h/%h want 12345678", bus.hi, bus.lo);
    end
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      errors++; $display("FAIL start_beats_move_result got %h/%h want %h/%h", bus.hi, bus.lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) rst = 1'b1;
    end
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", bus.hi, bus.lo);
    end
    for (int k = 0; k < Lat + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", stray); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu_timing();
    test_arith();
    test_start_while_busy();
    test_moves();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
